// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the small decode helpers used by both the controller and the datapath.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MADD  = 3'd4,
        MDU_MADDU = 3'd5,
        MDU_MSUB  = 3'd6,
        MDU_MSUBU = 3'd7
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Even encodings are the signed flavours (MULT, DIV, MADD, MSUB).
    function automatic logic is_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

    function automatic int mdu_latency(input logic [2:0] op,
                                       input int mul_cycles,
                                       input int div_cycles);
        return is_div(op) ? div_cycles : mul_cycles;
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational arithmetic for the multiply/divide unit. Produces the full
// {hi,lo} image for the latched op, including the divide special cases.
module mdu_core #(
    parameter int WIDTH = 32
) (
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic [2*WIDTH-1:0] base,
    output logic [2*WIDTH-1:0] result
);
    import mdu_pkg::*;

    localparam int W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};

    logic             sgn;
    logic [W2-1:0]    a_ext;
    logic [W2-1:0]    b_ext;
    logic [W2-1:0]    product;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    // Multiply on extended operands so one 2W-bit product serves both
    // signednesses; divide on magnitudes and re-apply signs (truncation).
    always_comb begin
        sgn     = is_signed(op);
        a_ext   = sgn ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
        b_ext   = sgn ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
        product = a_ext * b_ext;

        a_neg = sgn & src_a[WIDTH-1];
        b_neg = sgn & src_b[WIDTH-1];
        a_mag = a_neg ? -src_a : src_a;
        b_mag = b_neg ? -src_b : src_b;
        q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
        r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
        quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem   = a_neg ? -r_mag : r_mag;

        result = product;
        if (is_div(op)) begin
            if (src_b == '0) begin
                result = {src_a, ONES};
            end else if (sgn && (src_a == MIN_VAL) && (src_b == ONES)) begin
                result = {{WIDTH{1'b0}}, MIN_VAL};
            end else begin
                result = {rem, quot};
            end
        end else begin
            case (op)
                MDU_MADD, MDU_MADDU: result = base + product;
                MDU_MSUB, MDU_MSUBU: result = base - product;
                default:             result = product;
            endcase
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multiply/divide unit with HI/LO registers, start/busy handshake and flush.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | busy=0; accepts start, or mthi/mtlo writes when no start
//   ST_RUN  | busy=1; down-counter running, commit on terminal count
module mul_div_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);
    import mdu_pkg::*;

    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    mdu_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [2*WIDTH-1:0]  base_q, base_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic [2*WIDTH-1:0]  result;

    mdu_core #(.WIDTH(WIDTH)) u_core (
        .op     (op_q),
        .src_a  (a_q),
        .src_b  (b_q),
        .base   (base_q),
        .result (result)
    );

    // Next-state: flush beats start, start beats mthi/mtlo; commit on count 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        base_d  = base_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        cnt_d   = CNT_W'(mdu_latency(op, MUL_CYCLES, DIV_CYCLES));
                        op_d    = op;
                        a_d     = src_a;
                        b_d     = src_b;
                        base_d  = {hi_q, lo_q};
                    end else begin
                        if (mthi) hi_d = src_a;
                        if (mtlo) lo_d = src_a;
                    end
                end
                ST_RUN: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d       = ST_IDLE;
                        {hi_d, lo_d}  = result;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter, operand and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            base_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            base_q  <= base_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench: the same suite runs against a 32-bit (5/10 cycle) instance
// and a 16-bit (1/3 cycle) instance; sel16 picks which one is driven/observed.
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, mthi, mtlo, flush, sel16;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic [31:0] hi32, lo32;
    logic [15:0] hi16, lo16;
    logic        busy32, busy16;
    logic [31:0] hi_o, lo_o;
    logic        busy_o;

    int          n_vec = 0;
    int          n_err = 0;
    int          wid, mul_n, div_n;
    logic [31:0] ones, min_v;

    mul_div_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) u_dut32 (
        .clk   (clk),
        .reset (reset),
        .start (start & ~sel16),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .mthi  (mthi & ~sel16),
        .mtlo  (mtlo & ~sel16),
        .flush (flush & ~sel16),
        .hi    (hi32),
        .lo    (lo32),
        .busy  (busy32)
    );

    mul_div_unit #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .start (start & sel16),
        .op    (op),
        .src_a (src_a[15:0]),
        .src_b (src_b[15:0]),
        .mthi  (mthi & sel16),
        .mtlo  (mtlo & sel16),
        .flush (flush & sel16),
        .hi    (hi16),
        .lo    (lo16),
        .busy  (busy16)
    );

    always_comb begin
        hi_o   = sel16 ? {16'h0, hi16} : hi32;
        lo_o   = sel16 ? {16'h0, lo16} : lo32;
        busy_o = sel16 ? busy16 : busy32;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s (width %0d): observed %h expected %h", tag, wid, obs, exp);
        end
    endtask

    // Launch one op at a negedge, count busy cycles (bounded), check result.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic [31:0] eh, input logic [31:0] el,
                          input string tag, input bit interfere);
        int cycles;
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (busy_o && cycles < n + 4) begin
            if (interfere && cycles == 0) begin
                start = 1'b1; op = MDU_MULT; src_a = 32'h5; src_b = 32'h5;
                mthi = 1'b1; mtlo = 1'b1;
            end
            cycles++;
            @(negedge clk);
            start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        end
        check({tag, " busy_cycles"}, 32'(cycles), 32'(n));
        check({tag, " busy"}, {31'b0, busy_o}, 32'h0);
        check({tag, " hi"}, hi_o, eh);
        check({tag, " lo"}, lo_o, el);
    endtask

    task automatic run_suite();
        int k;
        ones  = (wid == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        min_v = (wid == 32) ? 32'h8000_0000 : 32'h0000_8000;

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset hi", hi_o, 32'h0);
        check("reset lo", lo_o, 32'h0);
        check("reset busy", {31'b0, busy_o}, 32'h0);

        run_op(MDU_MULT,  ones & 32'hFFFF_FFFE, 32'h3, mul_n, ones, ones & 32'hFFFF_FFFA, "mult -2x3", 1'b0);
        run_op(MDU_MULTU, ones, ones, mul_n, ones & 32'hFFFF_FFFE, 32'h1, "multu max*max", 1'b0);
        run_op(MDU_DIV,   ones & 32'hFFFF_FFF9, 32'h2, div_n, ones, ones & 32'hFFFF_FFFD, "div -7/2", 1'b0);
        run_op(MDU_DIVU,  32'h1234, 32'h0, div_n, 32'h1234, ones, "divu by zero", 1'b0);

        mthi = 1'b1; src_a = 32'h0;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b1; src_a = ones;
        @(negedge clk);
        mtlo = 1'b0;
        check("mthi hi", hi_o, 32'h0);
        check("mtlo lo", lo_o, ones);

        run_op(MDU_MADDU, 32'h1, 32'h1, mul_n, 32'h1, 32'h0, "maddu 1x1", 1'b0);
        run_op(MDU_MSUB,  32'h1, 32'h1, mul_n, 32'h0, ones, "msub 1x1", 1'b0);

        k = (mul_n < 3) ? mul_n : 3;
        op = MDU_MULT; src_a = 32'h3; src_b = 32'h4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (k - 1) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", {31'b0, busy_o}, 32'h0);
        check("flush hi", hi_o, 32'h0);
        check("flush lo", lo_o, ones);
        repeat (mul_n + 2) @(negedge clk);
        check("flush no late hi", hi_o, 32'h0);
        check("flush no late lo", lo_o, ones);

        op = MDU_MULT; src_a = 32'h3; src_b = 32'h4; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush+start busy", {31'b0, busy_o}, 32'h0);
        repeat (mul_n + 1) @(negedge clk);
        check("flush+start lo", lo_o, ones);

        run_op(MDU_DIV, 32'd100, 32'd7, div_n, 32'd2, 32'd14, "div ignore start/mthi/mtlo", 1'b1);
        run_op(MDU_DIV, min_v, ones, div_n, 32'h0, min_v, "div min/-1", 1'b0);

        op = MDU_MULT; src_a = 32'h3; src_b = 32'h4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("midop busy", {31'b0, busy_o}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midop reset hi", hi_o, 32'h0);
        check("midop reset lo", lo_o, 32'h0);
        check("midop reset busy", {31'b0, busy_o}, 32'h0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
        op = MDU_MULT; src_a = '0; src_b = '0;

        sel16 = 1'b0; wid = 32; mul_n = 5; div_n = 10;
        run_suite();

        sel16 = 1'b1; wid = 16; mul_n = 1; div_n = 3;
        run_suite();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised multiply/divide unit with HI/LO result registers for the pipelined MIPS core's EX stage. It runs signed and unsigned multiply, divide, multiply-accumulate and multiply-subtract with independently configurable latencies. It exposes a start/busy handshake that the hazard unit uses to stall dependent instructions, and a flush input so an in-flight operation can be cancelled without corrupting HI/LO. It replaces the fixed-width, multiply-only unit and runs on the rising edge of the core clock.

## Interface
- WIDTH, 32, operand and HI/LO width; must be ≥ 2
- MUL_CYCLES, 5, cycles from accepted start to commit for MULT/MULTU/MADD*/MSUB*; must be ≥ 1
- DIV_CYCLES, 10, cycles from accepted start to commit for DIV/DIVU; must be ≥ 1
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  launch operation `op` with `src_a`/`src_b` this cycle
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
- src_a  in  WIDTH  operand A (multiplicand / dividend)
- src_b  in  WIDTH  operand B (multiplier / divisor)
- mthi  in  1  write `src_a` into HI
- mtlo  in  1  write `src_a` into LO
- flush  in  1  cancel any in-flight operation; HI/LO keep their committed values
- hi  out  WIDTH  committed HI
- lo  out  WIDTH  committed LO
- busy  out  1  operation in flight; HI/LO are stale

## Operation
- Input priority each cycle: reset, then flush, then start, then mthi/mtlo.
- start is accepted only when busy=0.
  - On acceptance: latch op, src_a, src_b, and the current {hi,lo} as the accumulator base.
  - Load the counter with MUL_CYCLES or DIV_CYCLES according to op.
- start while busy=1 is ignored. The controller must stall instead.
- mthi/mtlo are applied only when busy=0 and start=0.
  - They are ignored while busy=1.
  - mthi and mtlo in the same cycle write both registers.
- Arithmetic results:
  - MULT/MULTU: {hi,lo} = 2·WIDTH-bit product, signed or unsigned.
  - MADD(U): {hi,lo} = base + product.
  - MSUB(U): {hi,lo} = base − product.
  - MADD/MSUB results are taken modulo 2^(2·WIDTH), with no overflow flag.
  - DIV/DIVU: lo = quotient truncated toward zero; hi = remainder, carrying the dividend's sign for signed division.
- Division boundary cases:
  - Divide by zero: lo = all-ones, hi = src_a. No trap.
  - Signed MIN / −1: lo = MIN, hi = 0.
- States:
  - IDLE (busy=0): goes to RUN on accepted start.
  - RUN (busy=1): the counter decrements each cycle. When it reaches 0, the result commits and the state returns to IDLE.
  - flush in RUN: returns to IDLE immediately with no commit.

## Timing
- Reset values: hi=0, lo=0, busy=0, counter=0, state IDLE.
- Reset in the middle of an operation aborts it, and HI/LO clear to 0.
- Commit timing: for start accepted at edge t with latency N, busy=1 in the cycles following edges t … t+N−1.
- At edge t+N the result is written and busy falls. New hi/lo and busy=0 are visible in the same cycle.
- Back-to-back operation: start may be asserted in the first cycle with busy=0. The accumulator base for that start is the just-committed HI/LO.
- flush takes effect at the next edge:
  - busy=0 and hi/lo unchanged after that edge.
  - flush together with start cancels the start.
- hi, lo and busy are all registered outputs. There is no combinational path from any input to any output.

## Structure
- Package mdu_pkg holds:
  - the 3-bit op encodings (MDU_MULT … MDU_MSUBU);
  - helper predicates is_div(op) and is_signed(op);
  - the latency-select function.
- Sub-module mdu_core holds the combinational arithmetic:
  - inputs: latched op, operands, base;
  - outputs: the 2·WIDTH-bit {hi,lo} result;
  - it includes the divide-by-zero and overflow special cases.
- The top level holds the FSM, counter, operand/base registers and HI/LO registers.

## Test plan
- Reset, then MULT src_a=0xFFFFFFFE (−2), src_b=3 → busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- DIV src_a=−7, src_b=2 → after 10 cycles lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). Repeat with DIVU src_b=0 → lo=0xFFFFFFFF, hi=src_a.
- mthi 0 and mtlo 0xFFFFFFFF, then MADDU 1×1 → hi=1, lo=0. Then MSUB 1×1 → hi=0, lo=0xFFFFFFFF.
- MULT 3×4 with flush asserted in its 3rd busy cycle → busy=0 on the next cycle; hi/lo keep their pre-start values; no late commit occurs.
- During a running DIV, assert start (MULT), mthi and mtlo → all ignored. The DIV result commits unaltered at cycle 10.
- DIV signed 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. Re-run the whole suite with WIDTH=16, MUL_CYCLES=1, DIV_CYCLES=3 → results scale accordingly, and with MUL_CYCLES=1 busy is high for exactly 1 cycle.
